// File: rtl/busca_instrucao.sv
// MIPS instruction-fetch stage: program counter, req/ready fetch from instruction
// memory, single-entry instruction register with stall and beq redirect/flush.
module busca_instrucao #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_data,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [31:0] pc_plus4,
    output logic        instr_valid,
    output logic [31:0] fetch_count
);

    typedef enum logic {
        S_REQ  = 1'b0,
        S_FULL = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic [31:0] count_q, count_d;
    logic        transfer;
    logic        unused_tgt_bits;

    assign unused_tgt_bits = &branch_target[1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_REQ;
            pc_q    <= PC_RESET;
            instr_q <= '0;
            pc4_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            count_q <= count_d;
        end
    end

    assign transfer = imem_req & imem_ready;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        pc4_d   = pc4_q;
        count_d = count_q;
        if (branch_taken) begin
            // The branch in the IR counts as consumed; the stale IR word is flushed.
            pc_d    = {branch_target[31:2], 2'b00};
            state_d = S_REQ;
            if (state_q == S_FULL) begin
                count_d = count_q + 32'd1;
            end
        end else begin
            case (state_q)
                S_REQ: begin
                    if (transfer) begin
                        instr_d = imem_data;
                        pc4_d   = pc_q + 32'd4;
                        pc_d    = pc_q + 32'd4;
                        state_d = S_FULL;
                    end
                end
                S_FULL: begin
                    if (!stall) begin
                        count_d = count_q + 32'd1;
                        if (transfer) begin
                            instr_d = imem_data;
                            pc4_d   = pc_q + 32'd4;
                            pc_d    = pc_q + 32'd4;
                        end else begin
                            state_d = S_REQ;
                        end
                    end
                end
                default: state_d = S_REQ;
            endcase
        end
    end

    always_comb begin
        imem_req = 1'b0;
        if (!reset && !branch_taken) begin
            imem_req = (state_q == S_REQ) || !stall;
        end
    end

    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign opcode      = instr_q[31:26];
    assign pc_plus4    = pc4_q;
    assign instr_valid = (state_q == S_FULL);
    assign fetch_count = count_q;

endmodule

// File: doc/busca_instrucao.md
# busca_instrucao

Instruction-fetch stage of the MIPS datapath, directly upstream of the main control decoder. Holds the program counter and sends word-aligned fetch requests to instruction memory over a req/ready handshake. Captures each returned word into a single-entry instruction register and presents it, with its 6-bit opcode field, to the control decoder and register file. Supports downstream stalls and taken-branch redirects (beq) with flush.

## Interface
- `PC_RESET`, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
- `clk` in 1: single clock, all state updates on rising edge.
- `reset` in 1: synchronous, active-high; overrides every other input.
- `imem_req` out 1: fetch request to instruction memory.
- `imem_addr` out 32: fetch address; equals `pc` whenever `imem_req`=1.
- `imem_ready` in 1: memory accepts the request and drives `imem_data` in the same cycle.
- `imem_data` in 32: instruction word, sampled only when `imem_req & imem_ready`.
- `stall` in 1: downstream hazard; instruction register must hold.
- `branch_taken` in 1: resolved beq for the instruction currently in the IR.
- `branch_target` in 32: redirect address; bits [1:0] ignored and forced to 0.
- `instr` out 32: instruction register.
- `opcode` out 6: `instr[31:26]`, feeds the control decoder `OPcode`.
- `pc_plus4` out 32: address of the IR instruction + 4, for branch-target adder.
- `instr_valid` out 1: IR holds a live instruction.
- `fetch_count` out 32: number of instructions delivered to decode.

## Operation
- Transfer: a cycle with `imem_req`=1 and `imem_ready`=1. `imem_req` may fall without a transfer; memory must not rely on it staying high.
- States: `REQ` (IR empty, fetching), `FULL` (IR valid).
- Priority each cycle: `reset` > `branch_taken` > `stall` > normal.
- `REQ`: `imem_req`=1. On transfer: `instr`<=`imem_data`, `pc_plus4`<=`pc`+4, `pc`<=`pc`+4, `instr_valid`<=1, go `FULL`. No transfer: hold.
- `FULL`, `stall`=1: `imem_req`=0; IR, `pc` and state hold.
- `FULL`, `stall`=0: IR is consumed this cycle; `fetch_count`+=1 (wraps 2^32-1 -> 0); `imem_req`=1 (prefetch).
  - With transfer: load IR as in `REQ`, stay `FULL`. This gives back-to-back throughput.
  - Without transfer: `instr_valid`<=0, go `REQ`.
- `branch_taken`=1, any state: `imem_req`=0 that cycle (no transfer); `pc`<={`branch_target`[31:2],2'b00}; `instr_valid`<=0; go `REQ`.
  - The branch instruction counts as consumed: `fetch_count`+=1 if `instr_valid`=1.
  - `stall` is ignored that cycle.
- `branch_taken` while `instr_valid`=0: redirect still applied, no count.
- PC arithmetic is modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0.

## Timing
- Reset (cycle with `reset`=1): `pc`=`PC_RESET`, `instr`=0, `opcode`=0, `pc_plus4`=0, `instr_valid`=0, `fetch_count`=0, state `REQ`, `imem_req`=0.
- First request is in the first cycle after `reset` falls, with `imem_addr`=`PC_RESET`.
- Latency: transfer in cycle N -> `instr`/`instr_valid` visible in cycle N+1.
- With `imem_ready` tied to 1 and `stall`=0, one instruction is delivered per cycle after a 1-cycle startup.
- `imem_req`/`imem_addr` are combinational from state, `pc`, `stall` and `branch_taken`. All other outputs are registered.
- Reset asserted mid-fetch: the pending transfer is discarded; all outputs take reset values next edge.
- `opcode`=0 decodes as R-type downstream; consumers must qualify with `instr_valid`.

## Test plan
- Reset, `PC_RESET`=0, `imem_ready`=1, memory returns addr-tagged words -> `imem_addr` 0,4,8,… on consecutive cycles; `instr` follows one cycle later; `fetch_count`=3 after 3 consumed.
- `imem_ready` low 3 cycles in `REQ` -> `imem_addr` held at same `pc`, `instr_valid`=0, then valid 1 cycle after ready.
- `stall` high 2 cycles in `FULL` -> `imem_req`=0, `instr` and `pc` unchanged, count frozen; resumes at `pc`+4 afterwards.
- `branch_taken`=1 with `stall`=1, `branch_target`=32'h0000_0043 -> next `imem_addr`=32'h0000_0040, `instr_valid`=0 for ≥1 cycle, count +1.
- `pc`=32'hFFFF_FFFC transfer -> next `imem_addr`=0, `pc_plus4`=0.
- `reset` asserted in the same cycle as a transfer -> `instr`=0, `instr_valid`=0, `fetch_count`=0, `pc`=`PC_RESET`.
